// File: rtl/sliding_window_gen.sv
// sliding_window_gen: streaming KxK neighbourhood generator.
//
// Builds a KxK pixel window from K-1 circular line buffers (FRAME_WIDTH words each) and
// a KxK shift-register array. x/y coordinates are generated internally from a start-of-frame
// marker. Two border modes are supported: VALID_ONLY (windows fully inside the frame) and
// ZERO_PAD (one window per pixel, out-of-frame taps forced to zero, top/left edges only).
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   en           pixel accepted on this edge
//   sof          accepted pixel is (0,0) of a new frame (ignored when en=0)
//   data_in      pixel value
//   border_mode  0 = VALID_ONLY, 1 = ZERO_PAD; sampled with each accepted pixel
//   window       tap(r,c) at [(r*K+c)*DATA_WIDTH +: DATA_WIDTH]; r=0 oldest row, c=0 oldest col
//   win_valid    window/win_x/win_y valid this cycle
//   win_x        column of the newest (bottom-right) pixel
//   win_y        row of the newest pixel
//   frame_done   one-cycle pulse after the last pixel of a frame is accepted

module sliding_window_gen #(
    parameter int DATA_WIDTH   = 8,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int K            = 3,
    parameter int XW           = $clog2(FRAME_WIDTH),
    parameter int YW           = $clog2(FRAME_HEIGHT)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        en,
    input  logic                        sof,
    input  logic [DATA_WIDTH-1:0]       data_in,
    input  logic                        border_mode,
    output logic [K*K*DATA_WIDTH-1:0]   window,
    output logic                        win_valid,
    output logic [XW-1:0]               win_x,
    output logic [YW-1:0]               win_y,
    output logic                        frame_done
);

    localparam int NB = K - 1;
    localparam logic [XW-1:0] X_LAST = XW'(FRAME_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FRAME_HEIGHT - 1);

    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;

    // Effective coordinates of the pixel presented this cycle; sof overrides the counters.
    logic [XW-1:0] px;
    logic [YW-1:0] py;

    logic [DATA_WIDTH-1:0] lb_mem [NB][FRAME_WIDTH];
    logic [DATA_WIDTH-1:0] lb_out [NB];
    logic [DATA_WIDTH-1:0] lb_in  [NB];

    // Raw (unmasked) window history; the output register holds the masked copy.
    logic [DATA_WIDTH-1:0] raw_q [K][K];
    logic [DATA_WIDTH-1:0] raw_d [K][K];

    logic [K*K*DATA_WIDTH-1:0] win_d;
    logic                      valid_d;
    logic                      last_pix;

    always_comb begin
        px = sof ? '0 : x_q;
        py = sof ? '0 : y_q;

        // Read-before-write: the old word at address px is popped into the next buffer.
        for (int i = 0; i < NB; i++) begin
            lb_out[i] = lb_mem[i][px];
        end
        lb_in[0] = data_in;
        for (int i = 1; i < NB; i++) begin
            lb_in[i] = lb_out[i-1];
        end

        // Shift columns left; newest column is {oldest buffer ... buffer 0, data_in}, top to bottom.
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                raw_d[r][c] = raw_q[r][c+1];
            end
        end
        raw_d[K-1][K-1] = data_in;
        for (int r = 0; r < K - 1; r++) begin
            raw_d[r][K-1] = lb_out[K-2-r];
        end

        // Zero-pad masking hides previous-row tails and stale/old-frame lines.
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                if (border_mode && ((int'(py) < K - 1 - r) || (int'(px) < K - 1 - c))) begin
                    win_d[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = '0;
                end else begin
                    win_d[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = raw_d[r][c];
                end
            end
        end

        valid_d  = border_mode || ((int'(px) >= K - 1) && (int'(py) >= K - 1));
        last_pix = (px == X_LAST) && (py == Y_LAST);
    end

    // Line-buffer storage is deliberately not reset; masking makes stale contents unobservable.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < NB; i++) begin
                lb_mem[i][px] <= lb_in[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q        <= '0;
            y_q        <= '0;
            raw_q      <= '{default: '0};
            window     <= '0;
            win_valid  <= 1'b0;
            win_x      <= '0;
            win_y      <= '0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (en) begin
                raw_q      <= raw_d;
                window     <= win_d;
                win_valid  <= valid_d;
                win_x      <= px;
                win_y      <= py;
                frame_done <= last_pix;
                if (px == X_LAST) begin
                    x_q <= '0;
                    y_q <= (py == Y_LAST) ? '0 : py + YW'(1);
                end else begin
                    x_q <= px + XW'(1);
                    y_q <= py;
                end
            end
        end
    end

endmodule

// File: doc/sliding_window_gen.md
Name: sliding_window_gen

Overview:
- Parametrised successor to the fixed 3x3 row-buffer front end of the detection pipeline.
- Accepts a pixel stream qualified by en and builds a KxK window from K-1 line buffers plus a KxK register array.
- Generates its own x/y coordinates from a start-of-frame marker. Offers two border modes.
- Feeds convolution stages (Sobel and wider kernels) and neighbourhood stages (connected components).

Parameters:
- DATA_WIDTH, 8: bits per pixel (word).
- FRAME_WIDTH, 640: pixels per row. Also the depth of each line buffer.
- FRAME_HEIGHT, 480: rows per frame.
- K, 3: window size. Odd, legal range 3..7.
- XW, $clog2(FRAME_WIDTH): column counter width.
- YW, $clog2(FRAME_HEIGHT): row counter width.

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  a pixel is accepted on this edge.
- sof  input  1  accepted pixel is (0,0) of a new frame. Ignored when en=0.
- data_in  input  DATA_WIDTH  pixel value.
- border_mode  input  1  0 = VALID_ONLY, 1 = ZERO_PAD. Sampled with each accepted pixel.
- window  output  K*K*DATA_WIDTH  tap(r,c) at bits [(r*K+c)*DATA_WIDTH +: DATA_WIDTH].
  - r=0 is the oldest row; c=0 is the oldest column.
  - tap(K-1,K-1) is the newest pixel.
- win_valid  output  1  window, win_x and win_y are valid this cycle.
- win_x  output  XW  column of the newest (bottom-right) pixel. Window centre is win_x-(K-1)/2.
- win_y  output  YW  row of the newest pixel.
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset: asynchronous on reset_n low.
  - window=0, win_valid=0, win_x=0, win_y=0, frame_done=0.
  - Internal x=0, y=0.
  - Line-buffer RAM contents are not reset. Masking rules below make stale data unobservable.
- Coordinates of an accepted pixel:
  - (0,0) if sof=1.
  - Otherwise the internal (x,y).
  - After acceptance, x increments. At FRAME_WIDTH-1, x wraps to 0 and y increments.
  - At (FRAME_WIDTH-1, FRAME_HEIGHT-1), both wrap to 0 and frame_done pulses on the next cycle.
  - A pixel after frame end without sof is (0,0) of the next frame.
- sof mid-frame: counters restart at the sof pixel. Old-frame data in the buffers is masked exactly as after reset.
- Line buffers: K-1 circular RAMs of FRAME_WIDTH words, addressed by the current x, read-before-write.
  - On acceptance, buffer i reads its old word at address x, then writes the word popped from buffer i-1 (buffer 0 writes data_in).
  - Column j of the window register array shifts left. Column K-1 loads {buffer K-2 out, ..., buffer 0 out, data_in}, rows top to bottom.
- Latency: window, win_x, win_y and win_valid are registered. They reflect the pixel accepted on the previous edge, i.e. 1 cycle.
- en=0: all state holds and the next cycle has win_valid=0. Output data registers hold their last values.
- VALID_ONLY: win_valid=1 only for pixels with x>=K-1 and y>=K-1. Taps are raw.
- ZERO_PAD: win_valid=1 for every accepted pixel.
  - Tap(r,c) is forced to 0 when y-(K-1-r)<0 or x-(K-1-c)<0.
  - This masks the previous row's tail and stale/old-frame lines.
  - Padding is causal: only the top and left edges are padded. Windows centred in the last (K-1)/2 rows/columns are not produced.
- border_mode change: takes effect from the next accepted pixel. There is no frame-boundary requirement.
- Simultaneous sof and the last pixel of a frame: sof wins. The pixel is (0,0) and frame_done does not pulse.
- Reset mid-frame: outputs clear immediately. The first pixel accepted after release is (0,0).

Test Plan:
Common setup: K=3, FRAME_WIDTH=8, FRAME_HEIGHT=4. Pixel (x,y) value = y*16+x. sof on the first pixel only.
1. Gapless frame, VALID_ONLY -> first win_valid on the cycle after pixel (2,2).
   - window taps row0..row2 = 00,01,02 / 10,11,12 / 20,21,22; win_x=2, win_y=2.
   - Exactly 12 valid windows; last one is (7,3).
2. Same frame, ZERO_PAD -> 32 valid windows.
   - At (1,0): taps = 0,0,0 / 0,0,0 / 0,00,01.
   - At (0,2): taps = 0,0,00 / 0,0,10 / 0,0,20 (column 0 mask hides row-1 tail values).
3. Repeat scenario 1 with en deasserted on random cycles (about 40%) -> same window/win_x/win_y sequence as gapless; win_valid never high after an en=0 cycle.
4. Two frames back-to-back with sof only on the very first pixel:
   - frame_done pulses once, the cycle after (7,3).
   - Second frame's first valid window (VALID_ONLY) is at (2,2) with the expected values.
   - No stale taps appear in ZERO_PAD.
5. sof asserted at pixel index 13 -> that pixel becomes (0,0). No VALID_ONLY window until the new (2,2), and no frame_done for the aborted frame.
6. reset_n pulsed low for 1 cycle at pixel (5,2), asynchronously mid-cycle -> all outputs 0 immediately. The next accepted pixel reports (0,0), and ZERO_PAD taps above it are 0.
